// File: rtl/accbuf_drain_arb.sv
// Round-robin drain of per-channel accumulator result FIFOs onto one tagged valid/ready stream.
// Optional ACCDRAIN_TSTAMP_EN adds a free-running capture timestamp per result (out_tstamp port).
module accbuf_drain_arb #(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 64,
    parameter int FIFOAW    = 2,
    parameter int SEQWIDTH  = 16,
    parameter int TCNTWIDTH = 27
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clear,
    input  logic [NREQ-1:0]                     in_valid,
    input  logic [NREQ*DATAWIDTH-1:0]           in_data,
    output logic [DATAWIDTH-1:0]                out_tdata,
    output logic [$clog2(NREQ)+SEQWIDTH-1:0]    out_tuser,
    output logic                                out_tvalid,
    input  logic                                out_tready,
    output logic [NREQ-1:0]                     overflow,
    output logic [NREQ*(FIFOAW+1)-1:0]          level_mon
`ifdef ACCDRAIN_TSTAMP_EN
    ,
    output logic [TCNTWIDTH-1:0]                out_tstamp
`endif
);
    localparam int CW    = $clog2(NREQ);
    localparam int DEPTH = 2**FIFOAW;
    localparam int LW    = FIFOAW + 1;

    if (NREQ < 2 || TCNTWIDTH < 1) begin : g_bad_param
        $error("accbuf_drain_arb: NREQ must be >= 2 and TCNTWIDTH >= 1");
    end

    logic [DATAWIDTH-1:0] mem_data [NREQ][DEPTH];
    logic [SEQWIDTH-1:0]  mem_seq  [NREQ][DEPTH];
    logic [FIFOAW-1:0]    wr_ptr   [NREQ];
    logic [FIFOAW-1:0]    rd_ptr   [NREQ];
    logic [LW-1:0]        level    [NREQ];
    logic [SEQWIDTH-1:0]  seq      [NREQ];
    logic [CW-1:0]        rr_ptr;
    logic [CW-1:0]        gnt;
    logic                 gnt_valid;
    logic                 load;
    logic [NREQ-1:0]      full;
    logic [NREQ-1:0]      push;
    logic [NREQ-1:0]      pop;

`ifdef ACCDRAIN_TSTAMP_EN
    logic [TCNTWIDTH-1:0] mem_ts [NREQ][DEPTH];
    logic [TCNTWIDTH-1:0] tcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     tcnt <= '0;
        else if (clear) tcnt <= '0;
        else            tcnt <= tcnt + TCNTWIDTH'(1);
    end
`endif

    assign load = ~out_tvalid | out_tready;

    // full is taken from the registered level, so a pop in the same cycle never frees room for a push
    always_comb begin
        full = '0;
        push = '0;
        pop  = '0;
        for (int i = 0; i < NREQ; i++) begin
            full[i] = (level[i] == LW'(DEPTH));
            push[i] = in_valid[i] & ~full[i] & ~clear;
            pop[i]  = load & gnt_valid & (gnt == CW'(i)) & ~clear;
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_valid && level[idx] != '0) begin
                gnt_valid = 1'b1;
                gnt       = CW'(idx);
            end
        end
    end

    always_comb begin
        level_mon = '0;
        for (int i = 0; i < NREQ; i++) level_mon[i*LW +: LW] = level[i];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                mem_data[i][wr_ptr[i]] <= in_data[i*DATAWIDTH +: DATAWIDTH];
                mem_seq[i][wr_ptr[i]]  <= seq[i];
`ifdef ACCDRAIN_TSTAMP_EN
                mem_ts[i][wr_ptr[i]]   <= tcnt;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                level[i]  <= '0;
                seq[i]    <= '0;
            end
            overflow   <= '0;
            rr_ptr     <= CW'(NREQ - 1);
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tuser  <= '0;
`ifdef ACCDRAIN_TSTAMP_EN
            out_tstamp <= '0;
`endif
        end else if (clear) begin
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                level[i]  <= '0;
                seq[i]    <= '0;
            end
            overflow   <= '0;
            rr_ptr     <= CW'(NREQ - 1);
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tuser  <= '0;
`ifdef ACCDRAIN_TSTAMP_EN
            out_tstamp <= '0;
`endif
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + FIFOAW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + FIFOAW'(1);
                // dropped results still consume a sequence number so the host can see the gap
                if (in_valid[i]) seq[i] <= seq[i] + SEQWIDTH'(1);
                if (in_valid[i] & full[i]) overflow[i] <= 1'b1;
                level[i] <= level[i] + LW'(push[i]) - LW'(pop[i]);
            end
            if (load) begin
                out_tvalid <= gnt_valid;
                if (gnt_valid) begin
                    out_tdata  <= mem_data[gnt][rd_ptr[gnt]];
                    out_tuser  <= {gnt, mem_seq[gnt][rd_ptr[gnt]]};
                    rr_ptr     <= gnt;
`ifdef ACCDRAIN_TSTAMP_EN
                    out_tstamp <= mem_ts[gnt][rd_ptr[gnt]];
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_accbuf_drain_arb.sv
// Directed bench for accbuf_drain_arb: latency, RR order, overflow/seq gaps, streaming, async reset.
module tb_accbuf_drain_arb;
    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int UW   = 2 + 16;
    localparam int LW   = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic [NREQ-1:0]    in_valid;
    logic [NREQ*DW-1:0] in_data;
    logic [DW-1:0]      out_tdata;
    logic [UW-1:0]      out_tuser;
    logic               out_tvalid;
    logic               out_tready;
    logic [NREQ-1:0]    overflow;
    logic [NREQ*LW-1:0] level_mon;
`ifdef ACCDRAIN_TSTAMP_EN
    logic [26:0]        out_tstamp;
`endif

    int checks = 0;
    int errors = 0;

    accbuf_drain_arb dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_data(in_data),
        .out_tdata(out_tdata), .out_tuser(out_tuser),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .overflow(overflow), .level_mon(level_mon)
`ifdef ACCDRAIN_TSTAMP_EN
        , .out_tstamp(out_tstamp)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [DW+UW-1:0] exp_q [NREQ][$];
    logic [DW+UW-1:0] ent;
    logic [31:0]      cnt [NREQ];
    logic             hold_prev;
    logic [DW-1:0]    prev_data;
    logic [UW-1:0]    prev_user;
    int               beats;

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = '0; in_data = '0; out_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 128'(out_tvalid), 128'(0));
        check("rst_overflow", 128'(overflow), 128'(0));
        check("rst_level", 128'(level_mon), 128'(0));
        reset = 1'b1;
        tick();

        // 1: single result, two-cycle latency
        in_valid = 4'b0001; in_data[0 +: DW] = 64'h1;
        tick();
        in_valid = '0;
        check("t1_not_yet", 128'(out_tvalid), 128'(0));
        check("t1_level", 128'(level_mon[0 +: LW]), 128'(1));
        tick();
        check("t1_tvalid", 128'(out_tvalid), 128'(1));
        check("t1_tdata", 128'(out_tdata), 128'(64'h1));
        check("t1_tuser", 128'(out_tuser), 128'(0));
        tick();
        check("t1_one_beat", 128'(out_tvalid), 128'(0));

        // 2: simultaneous push on all channels drains in order 0,1,2,3
        do_clear();
        in_valid = 4'b1111;
        for (int c = 0; c < NREQ; c++) in_data[c*DW +: DW] = 64'(64'hA + c);
        tick();
        in_valid = '0;
        for (int c = 0; c < NREQ; c++) begin
            tick();
            check("t2_tvalid", 128'(out_tvalid), 128'(1));
            check("t2_tdata", 128'(out_tdata), 128'(64'hA + c));
            check("t2_tuser", 128'(out_tuser), 128'({2'(c), 16'd0}));
        end
        tick();
        check("t2_drained", 128'(out_tvalid), 128'(0));

        // 3: ch1 x6 with stalled output; output register absorbs seq0, FIFO holds 1..4, seq5 dropped
        do_clear();
        out_tready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 4'b0010; in_data[DW +: DW] = 64'(64'h100 + k);
            tick();
            if (k == 4) check("t3_no_ovf_yet", 128'(overflow), 128'(0));
        end
        in_valid = '0;
        check("t3_overflow", 128'(overflow), 128'(4'b0010));
        check("t3_level", 128'(level_mon[LW +: LW]), 128'(4));
        check("t3_hold_user", 128'(out_tuser), 128'({2'd1, 16'd0}));
        tick();
        check("t3_hold_stable", 128'(out_tdata), 128'(64'h100));
        out_tready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t3_seq", 128'(out_tuser), 128'({2'd1, 16'(k)}));
            check("t3_data", 128'(out_tdata), 128'(64'h100 + k));
        end
        tick();
        check("t3_drained", 128'(out_tvalid), 128'(0));
        in_valid = 4'b0010; in_data[DW +: DW] = 64'h1FF;
        tick();
        in_valid = '0;
        tick();
        check("t3_seq_gap", 128'(out_tuser), 128'({2'd1, 16'd6}));
        check("t3_gap_data", 128'(out_tdata), 128'(64'h1FF));
        tick();

        // 4: staggered streaming on all channels with a stalling sink
        do_clear();
        for (int c = 0; c < NREQ; c++) cnt[c] = '0;
        hold_prev = 1'b0; prev_data = '0; prev_user = '0; beats = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            in_valid = '0;
            for (int c = 0; c < NREQ; c++) begin
                if (cyc < 64 && (cyc % 8) == 2 * c) begin
                    in_valid[c] = 1'b1;
                    in_data[c*DW +: DW] = {32'(c), cnt[c]};
                    exp_q[c].push_back({{32'(c), cnt[c]}, 2'(c), 16'(cnt[c])});
                    cnt[c] = cnt[c] + 1;
                end
            end
            out_tready = ((cyc % 4) != 3);
            if (hold_prev) begin
                check("t4_hold_valid", 128'(out_tvalid), 128'(1));
                check("t4_hold_data", 128'(out_tdata), 128'(prev_data));
                check("t4_hold_user", 128'(out_tuser), 128'(prev_user));
            end
            if (out_tvalid && out_tready) begin
                if (exp_q[out_tuser[17:16]].size() == 0) begin
                    check("t4_unexpected_beat", 128'(out_tuser), 128'(0));
                end else begin
                    ent = exp_q[out_tuser[17:16]].pop_front();
                    check("t4_beat", 128'({out_tdata, out_tuser}), 128'(ent));
                    beats++;
                end
            end
            hold_prev = out_tvalid && !out_tready;
            prev_data = out_tdata;
            prev_user = out_tuser;
            tick();
        end
        in_valid = '0;
        out_tready = 1'b1;
        check("t4_beat_count", 128'(beats), 128'(32));
        check("t4_no_overflow", 128'(overflow), 128'(0));

        // 5: async reset while holding a beat, then ch0 wins over ch2
        do_clear();
        out_tready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 4'b0010; in_data[DW +: DW] = 64'(k);
            tick();
        end
        in_valid = '0;
        check("t5_pre_tvalid", 128'(out_tvalid), 128'(1));
        check("t5_pre_ovf", 128'(overflow), 128'(4'b0010));
        #2 reset = 1'b0;
        #1;
        check("t5_rst_tvalid", 128'(out_tvalid), 128'(0));
        check("t5_rst_ovf", 128'(overflow), 128'(0));
        check("t5_rst_level", 128'(level_mon), 128'(0));
        tick();
        reset = 1'b1;
        out_tready = 1'b1;
        in_valid = 4'b0101;
        in_data[0 +: DW] = 64'h50; in_data[2*DW +: DW] = 64'h52;
        tick();
        in_valid = '0;
        tick();
        check("t5_first", 128'({out_tvalid, out_tdata, out_tuser}), 128'({1'b1, 64'h50, 2'd0, 16'd0}));
        tick();
        check("t5_second", 128'({out_tvalid, out_tdata, out_tuser}), 128'({1'b1, 64'h52, 2'd2, 16'd0}));
        tick();

`ifdef ACCDRAIN_TSTAMP_EN
        // 6: timestamp captured at push, shown with the beat
        do_clear();
        out_tready = 1'b0;
        repeat (100) tick();
        in_valid = 4'b1000; in_data[3*DW +: DW] = 64'h33;
        tick();
        in_valid = '0;
        repeat (9) tick();
        check("t6_tstamp", 128'(out_tstamp), 128'(100));
        check("t6_tuser", 128'(out_tuser), 128'({2'd3, 16'd0}));
        out_tready = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
